// File: rtl/oled_spi_streamer.sv
// SSD1306-style OLED streamer: panel reset, 12-byte init, then 1024-byte frames over SPI mode 0.
// Ports: clk/rst (async high), enable, data_to_send in; byte_counter, oled_* SPI pins, frame_done out.
module oled_spi_streamer #(
  parameter int CLK_DIV    = 4,
  parameter int RES_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [7:0] data_to_send,
  output logic [9:0] byte_counter,
  output logic       oled_sclk,
  output logic       oled_mosi,
  output logic       oled_cs,
  output logic       oled_dc,
  output logic       oled_res,
  output logic       frame_done
);

  localparam int RW = (RES_CYCLES < 2) ? 1 : $clog2(RES_CYCLES);
  localparam logic [RW-1:0] RES_M1 = RW'(RES_CYCLES - 1);
  localparam logic [7:0]    DIV_M1 = 8'(CLK_DIV - 1);

  localparam logic [2:0] S_RES_LOW  = 3'd0;
  localparam logic [2:0] S_RES_WAIT = 3'd1;
  localparam logic [2:0] S_INIT     = 3'd2;
  localparam logic [2:0] S_IDLE     = 3'd3;
  localparam logic [2:0] S_FETCH    = 3'd4;
  localparam logic [2:0] S_DATA     = 3'd5;

  localparam logic [1:0] P_LOAD  = 2'd0;
  localparam logic [1:0] P_SHIFT = 2'd1;
  localparam logic [1:0] P_GAP   = 2'd2;

  logic [2:0]    r_state;
  logic [RW-1:0] r_rcnt;
  logic [1:0]    r_phase;
  logic [7:0]    r_div;
  logic          r_sclk;
  logic [2:0]    r_bit;
  logic [7:0]    r_sh;
  logic [3:0]    r_cmd;
  logic [9:0]    r_bc;
  logic          r_fetch;
  logic          r_fd;

  logic w_active;
  logic w_gap;

  function automatic logic [7:0] f_cmd(input logic [3:0] idx);
    case (idx)
      4'd0:    f_cmd = 8'hAE;
      4'd1:    f_cmd = 8'h8D;
      4'd2:    f_cmd = 8'h14;
      4'd3:    f_cmd = 8'h20;
      4'd4:    f_cmd = 8'h00;
      4'd5:    f_cmd = 8'h21;
      4'd6:    f_cmd = 8'h00;
      4'd7:    f_cmd = 8'h7F;
      4'd8:    f_cmd = 8'h22;
      4'd9:    f_cmd = 8'h00;
      4'd10:   f_cmd = 8'h07;
      default: f_cmd = 8'hAF;
    endcase
  endfunction

  // A byte is on the wire only in INIT and DATA; the gap
  // cycle is its last cycle, with cs already high.
  assign w_active = (r_state == S_INIT) || (r_state == S_DATA);
  assign w_gap    = (r_phase == P_GAP);

  assign oled_cs      = ~(w_active && !w_gap);
  assign oled_sclk    = w_active && (r_phase == P_SHIFT) && r_sclk;
  assign oled_mosi    = w_active && !w_gap && r_sh[7];
  assign oled_dc      = (r_state == S_DATA);
  assign oled_res     = (r_state != S_RES_LOW);
  assign byte_counter = r_bc;
  assign frame_done   = r_fd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_RES_LOW;
      r_rcnt  <= '0;
      r_phase <= P_LOAD;
      r_div   <= '0;
      r_sclk  <= 1'b0;
      r_bit   <= '0;
      r_sh    <= '0;
      r_cmd   <= '0;
      r_bc    <= '0;
      r_fetch <= 1'b0;
      r_fd    <= 1'b0;
    end else begin
      r_fd <= 1'b0;

      // Byte shifter: load, 8 x (low,high) half-periods, gap.
      if (w_active) begin
        case (r_phase)
          P_LOAD: begin
            r_phase <= P_SHIFT;
            r_div   <= '0;
            r_sclk  <= 1'b0;
            r_bit   <= '0;
          end
          P_SHIFT: begin
            if (r_div == DIV_M1) begin
              r_div <= '0;
              if (!r_sclk) begin
                r_sclk <= 1'b1;
              end else begin
                r_sclk <= 1'b0;
                if (r_bit == 3'd7) begin
                  r_phase <= P_GAP;
                end else begin
                  r_bit <= r_bit + 3'd1;
                  r_sh  <= {r_sh[6:0], 1'b0};
                end
              end
            end else begin
              r_div <= r_div + 8'd1;
            end
          end
          default: r_phase <= P_LOAD;
        endcase
      end

      case (r_state)
        S_RES_LOW: begin
          if (r_rcnt == RES_M1) begin
            r_rcnt  <= '0;
            r_state <= S_RES_WAIT;
          end else begin
            r_rcnt <= r_rcnt + 1'b1;
          end
        end
        S_RES_WAIT: begin
          if (r_rcnt == RES_M1) begin
            r_rcnt  <= '0;
            r_state <= S_INIT;
            r_cmd   <= '0;
            r_sh    <= f_cmd(4'd0);
            r_phase <= P_LOAD;
          end else begin
            r_rcnt <= r_rcnt + 1'b1;
          end
        end
        S_INIT: begin
          if (w_gap) begin
            if (r_cmd == 4'd11) begin
              r_state <= S_IDLE;
            end else begin
              r_cmd <= r_cmd + 4'd1;
              r_sh  <= f_cmd(r_cmd + 4'd1);
            end
          end
        end
        S_IDLE: begin
          if (enable) begin
            r_state <= S_FETCH;
            r_bc    <= '0;
            r_fetch <= 1'b0;
          end
        end
        S_FETCH: begin
          // Controller registers data one clk after the index
          // moves, so capture on the second fetch cycle.
          if (!r_fetch) begin
            r_fetch <= 1'b1;
          end else begin
            r_sh    <= data_to_send;
            r_phase <= P_LOAD;
            r_state <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_gap) begin
            r_fetch <= 1'b0;
            if (r_bc == 10'd1023) begin
              r_fd    <= 1'b1;
              r_bc    <= '0;
              r_state <= enable ? S_FETCH : S_IDLE;
            end else begin
              r_bc    <= r_bc + 10'd1;
              r_state <= S_FETCH;
            end
          end
        end
        default: r_state <= S_RES_LOW;
      endcase
    end
  end

endmodule

// File: tb/tb_oled_spi_streamer.sv
// Bench for oled_spi_streamer: pin table after reset, SPI byte decoder
// compared with an expected byte stream (init list, then indexed data).
module tb_oled_spi_streamer;

  localparam int CLK_DIV    = 2;
  localparam int RES_CYCLES = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic [7:0] data_to_send = 8'h00;
  logic [9:0] byte_counter;
  logic       oled_sclk, oled_mosi, oled_cs;
  logic       oled_dc, oled_res, frame_done;

  oled_spi_streamer #(
    .CLK_DIV   (CLK_DIV),
    .RES_CYCLES(RES_CYCLES)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .data_to_send(data_to_send),
    .byte_counter(byte_counter),
    .oled_sclk   (oled_sclk),
    .oled_mosi   (oled_mosi),
    .oled_cs     (oled_cs),
    .oled_dc     (oled_dc),
    .oled_res    (oled_res),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // Image controller model: frame 0 returns the index,
  // later frames return a random image.
  logic [7:0] mem [1024];
  logic       sel = 1'b0;
  always @(posedge clk)
    data_to_send <= sel ? mem[byte_counter] : byte_counter[7:0];

  logic [7:0] cmds [12] = '{8'hAE, 8'h8D, 8'h14, 8'h20,
                            8'h00, 8'h21, 8'h00, 8'h7F,
                            8'h22, 8'h00, 8'h07, 8'hAF};

  // SPI decoder / reference comparison
  int   cyc = 0, ncmd = 0, ndata = 0, nfd = 0, nfalls = 0;
  int   bits = 0, last_fall = 0;
  logic in_byte = 1'b0, bdc = 1'b0;
  logic prev_cs = 1'b1, prev_sclk = 1'b0;
  logic prev_mosi = 1'b0, prev_fd = 1'b0;
  logic [7:0] sh = 8'h00;

  always @(negedge clk) begin
    int idx;
    logic [7:0] exp;
    cyc++;
    if (rst) begin
      in_byte = 1'b0;
      ncmd = 0;
      nfalls = 0;
      prev_cs = 1'b1;
      prev_sclk = 1'b0;
      prev_mosi = 1'b0;
      prev_fd = 1'b0;
    end else begin
      if (!oled_cs && !prev_cs && oled_mosi != prev_mosi)
        chk("mosi_edge", 32'(prev_sclk && !oled_sclk), 1);
      if (!oled_cs && prev_cs) begin
        in_byte = 1'b1;
        bits = 0;
        sh = 8'h00;
        bdc = oled_dc;
        if (!oled_dc && ncmd > 0)
          chk("cmd_period", 32'(cyc - last_fall), 34);
        if (oled_dc) begin
          idx = ndata % 1024;
          chk("bc_at_load", 32'(byte_counter), 32'(idx));
          if (idx != 0)
            chk("data_period", 32'(cyc - last_fall), 36);
        end
        last_fall = cyc;
        nfalls++;
      end else if (!oled_cs && in_byte) begin
        if (oled_sclk && !prev_sclk) begin
          sh = {sh[6:0], oled_mosi};
          bits++;
        end
        if (oled_dc != bdc)
          chk("dc_hold", 32'(oled_dc), 32'(bdc));
      end
      if (oled_cs && !prev_cs && in_byte) begin
        in_byte = 1'b0;
        chk("bit_count", 32'(bits), 8);
        if (!bdc) begin
          chk("cmd_slot", 32'(ncmd < 12), 1);
          if (ncmd < 12)
            chk("cmd_byte", 32'(sh), 32'(cmds[ncmd]));
          ncmd++;
        end else begin
          idx = ndata % 1024;
          exp = (ndata < 1024) ? 8'(idx) : mem[idx];
          chk("data_after_init", 32'(ncmd), 12);
          chk("data_byte", 32'(sh), 32'(exp));
          ndata++;
        end
      end
      if (frame_done) begin
        nfd++;
        sel = 1'b1;
        chk("fd_width", 32'(prev_fd), 0);
        chk("fd_bc", 32'(byte_counter), 0);
        chk("fd_index", 32'(ndata % 1024), 0);
      end
      prev_cs = oled_cs;
      prev_sclk = oled_sclk;
      prev_mosi = oled_mosi;
      prev_fd = frame_done;
    end
  end

  typedef struct {
    int   cyc;
    logic en;
    logic res, cs, sclk, mosi, dc, fd;
    logic [9:0] bc;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input int c, input logic res, input logic cs,
                     input logic sclk, input logic mosi);
    vec_t v;
    v.cyc = c; v.en = 1'b0;
    v.res = res; v.cs = cs; v.sclk = sclk; v.mosi = mosi;
    v.dc = 1'b0; v.fd = 1'b0; v.bc = 10'd0;
    tbl.push_back(v);
  endtask

  function automatic logic [31:0] pins();
    return 32'({oled_res, oled_cs, oled_sclk, oled_mosi,
                oled_dc, frame_done, byte_counter});
  endfunction

  // Releases rst and walks the pin table, cycle 0 being
  // the cycle right after release.
  task automatic run_table();
    int k;
    k = 0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    foreach (tbl[i]) begin
      while (k < tbl[i].cyc) begin
        @(negedge clk);
        #1;
        k++;
      end
      enable = tbl[i].en;
      chk($sformatf("vec%0d_c%0d", i, tbl[i].cyc), pins(),
          32'({tbl[i].res, tbl[i].cs, tbl[i].sclk, tbl[i].mosi,
               tbl[i].dc, tbl[i].fd, tbl[i].bc}));
    end
  endtask

  task automatic wait_init(input string nm);
    int i;
    for (i = 0; i < 1000 && ncmd < 12; i++) @(negedge clk);
    #1;
    chk(nm, 32'(ncmd), 12);
  endtask

  initial begin
    int i;
    for (int j = 0; j < 1024; j++) mem[j] = 8'($urandom);
    // 0xAE = 1010_1110 MSB first; load at 8, gap at 41
    add(0,  0, 1, 0, 0);
    add(3,  0, 1, 0, 0);
    add(4,  1, 1, 0, 0);
    add(7,  1, 1, 0, 0);
    add(8,  1, 0, 0, 1);
    add(10, 1, 0, 0, 1);
    add(11, 1, 0, 1, 1);
    add(13, 1, 0, 0, 0);
    add(15, 1, 0, 1, 0);
    add(17, 1, 0, 0, 1);
    add(21, 1, 0, 0, 0);
    add(25, 1, 0, 0, 1);
    add(37, 1, 0, 0, 0);
    add(39, 1, 0, 1, 0);
    add(41, 1, 1, 0, 0);
    add(42, 1, 0, 0, 1);

    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_pins", pins(), 32'h4000);

    run_table();
    wait_init("init_done");

    repeat (300) @(negedge clk);
    #1;
    chk("idle_ncmd", 32'(ncmd), 12);
    chk("idle_falls", 32'(nfalls), 12);
    chk("idle_ndata", 32'(ndata), 0);
    chk("idle_pins", pins(), 32'h4000 | 32'h8000);

    enable = 1'b1;
    for (i = 0; i < 40000 && nfd < 1; i++) @(negedge clk);
    #1;
    chk("frame1_done", 32'(nfd), 1);
    chk("frame1_len", 32'(ndata), 1024);

    for (i = 0; i < 40000 && ndata < 1524; i++) begin
      @(negedge clk);
      enable = 1'($urandom);
    end
    enable = 1'b0;
    for (i = 0; i < 40000 && nfd < 2; i++) @(negedge clk);
    #1;
    chk("frame2_done", 32'(nfd), 2);
    chk("frame2_len", 32'(ndata), 2048);

    repeat (500) @(negedge clk);
    #1;
    chk("stay_idle_ndata", 32'(ndata), 2048);
    chk("stay_idle_fd", 32'(nfd), 2);
    chk("stay_idle_pins", pins(), 32'hC000);

    enable = 1'b1;
    for (i = 0; i < 2000; i++) begin
      @(negedge clk);
      #1;
      if (in_byte && bdc && ndata >= 2051 && bits == 4 && !oled_sclk)
        break;
    end
    chk("reach_bit3", 32'(in_byte && bits == 4 && ndata == 2051), 1);
    chk("bc_before_abort", 32'(byte_counter), 3);
    rst = 1'b1;
    #1;
    chk("abort_pins", pins(), 32'h4000);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("abort_hold", pins(), 32'h4000);

    run_table();
    wait_init("reinit_done");
    chk("reinit_ndata", 32'(ndata), 2051);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/oled_spi_streamer.md
OLED_SPI_STREAMER -- requirements
Module: oled_spi_streamer

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 4, giving SPI SCLK half-period in clk cycles (legal values 1 to 255).
REQ-002 The block SHALL have parameter RES_CYCLES, default 20000, giving the panel reset-low time and the post-reset wait, each in clk cycles (legal values 1 or more).
REQ-003 clk  input  1  system clock, all logic on posedge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 enable  input  1  permits a new frame to start.
REQ-006 data_to_send  input  8  frame byte from the image controller, registered by that block one clk after byte_counter changes.
REQ-007 byte_counter  output  10  frame byte index requested from the image controller, range 0..1023.
REQ-008 oled_sclk  output  1  SPI clock, mode 0.
REQ-009 oled_mosi  output  1  SPI data, MSB first.
REQ-010 oled_cs  output  1  chip select, active-low.
REQ-011 oled_dc  output  1  0 = command byte, 1 = display-data byte.
REQ-012 oled_res  output  1  panel reset, active-low.
REQ-013 frame_done  output  1  one-cycle pulse when the last frame byte completes.

Function
REQ-014 States SHALL be RES_LOW, RES_WAIT, INIT, IDLE, FETCH, DATA.
- RES_LOW: oled_res=0 for RES_CYCLES cycles, then go to RES_WAIT.
- RES_WAIT: oled_res=1 for RES_CYCLES cycles, then go to INIT.
REQ-015 INIT SHALL send 12 command bytes (oled_dc=0) in this order: AE 8D 14 20 00 21 00 7F 22 00 07 AF (hex), then go to IDLE.
REQ-016 IDLE SHALL go to FETCH with byte_counter=0 on the first cycle that enable=1.
REQ-017 FETCH SHALL take exactly 2 cycles: byte_counter is held stable, data_to_send is captured on the 2nd cycle, then the state goes to DATA.
REQ-018 DATA SHALL send the captured byte with oled_dc=1, then:
- if byte_counter<1023: increment byte_counter and go to FETCH;
- if byte_counter=1023: pulse frame_done for 1 cycle, set byte_counter to 0, go to FETCH if enable=1, otherwise go to IDLE.
REQ-019 Byte shifter timing SHALL be as follows:
- Load cycle: oled_cs=0, oled_mosi=bit7, oled_sclk=0.
- Each bit b7..b0: oled_sclk low for CLK_DIV cycles, then high for CLK_DIV cycles.
- oled_mosi changes only on a high-to-low SCLK transition, and at load.
- After the b0 high phase: oled_sclk=0, and oled_cs=1 for exactly 1 cycle before the next load.
- Byte time is 16*CLK_DIV+2 cycles, load and cs-high cycle included.
REQ-020 oled_dc SHALL be valid at load and held constant until oled_cs returns high.
REQ-021 When no byte is in progress, outputs SHALL idle at oled_cs=1, oled_sclk=0, oled_mosi=0.
REQ-022 byte_counter SHALL change only on entry to FETCH; the 10-bit value wraps 1023 to 0 and never exceeds 1023.
REQ-023 enable falling mid-frame SHALL NOT abort the frame; it is sampled only in IDLE and at frame end.
REQ-024 INIT SHALL run only once after each reset; later frames send data bytes only, with no command bytes between frames.

Reset
REQ-025 While rst=1, all of the following SHALL hold regardless of clk:
- state=RES_LOW, oled_res=0, oled_cs=1, oled_sclk=0, oled_mosi=0, oled_dc=0;
- byte_counter=0, frame_done=0;
- all counters cleared.
REQ-026 Asserting rst mid-byte or mid-frame SHALL abort the transfer immediately.
REQ-027 Release of rst SHALL restart the full RES_LOW, RES_WAIT, INIT sequence.

Verification
Bench parameters: CLK_DIV=2, RES_CYCLES=4.
REQ-028 Release rst -> oled_res=0 for 4 cycles, then 1; the first oled_cs fall comes 4 cycles later; the first byte decoded is 0xAE with oled_dc=0.
REQ-029 Full INIT with enable=0 -> exactly 12 bytes decoded, matching REQ-015; then idle with oled_cs=1 and no further activity.
REQ-030 enable=1, and a model returns data_to_send=byte_counter[7:0] one cycle after byte_counter changes -> 1024 data bytes decoded as 00,01,...,FF repeating, all with oled_dc=1; frame_done pulses once, 1 cycle wide, after the byte at index 1023; byte period is 34 cycles of shifting plus 2 fetch cycles.
REQ-031 enable held at 1 across a frame end -> next byte requested is byte_counter=0; no command bytes are sent between frames.
REQ-032 enable dropped at index 500 -> frame continues to index 1023, frame_done pulses, then the block stays in IDLE.
REQ-033 rst asserted during bit 3 of a data byte -> oled_cs=1, oled_sclk=0 and byte_counter=0 immediately, asynchronously; after release the block repeats the sequence of REQ-028.
